// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection and branch flush; 1-cycle latency (2 during a load-use stall).
// Backpressure: stall holds fetch and IF/ID for one cycle; a taken branch (pc_mux_sel) squashes the held instruction.
module if_id_hazard_stage #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(32'h00000013),
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inst_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] pc_plus4_in,
  input  logic             pc_mux_sel,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4_out,
  output logic             valid_out,
  output logic             stall,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stat_issued,
  output logic [CNT_W-1:0] stat_stalls
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       use_rs1, use_rs2;
  logic       hazard;

  assign opcode = inst_out[6:0];
  assign rs1    = inst_out[19:15];
  assign rs2    = inst_out[24:20];

  // R-type, stores and branches read two sources; OP-IMM, loads and JALR read rs1 only.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        use_rs1 = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
    endcase
  end

  assign hazard = valid_out & ex_mem_read & (ex_rd != 5'd0) &
                  ((use_rs1 & (ex_rd == rs1)) | (use_rs2 & (ex_rd == rs2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // A flush always lands in RUN: in RUN it suppresses the stall, and HOLD always exits.
  always_comb begin
    state_nxt = RUN;
    stall     = 1'b0;
    case (state)
      RUN: begin
        stall = hazard & ~pc_mux_sel;
        if (stall) state_nxt = HOLD;
      end
      HOLD: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign id_bubble = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_out     <= NOP;
      pc_out       <= '0;
      pc_plus4_out <= '0;
      valid_out    <= 1'b0;
    end else if (pc_mux_sel) begin
      inst_out     <= NOP;
      pc_out       <= pc_in;
      pc_plus4_out <= pc_plus4_in;
      valid_out    <= 1'b0;
    end else if (!stall) begin
      inst_out     <= inst_in;
      pc_out       <= pc_in;
      pc_plus4_out <= pc_plus4_in;
      valid_out    <= 1'b1;
    end
  end

  // A valid instruction counts as issued whenever it leaves unstalled, even if squashed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued <= '0;
      stat_stalls <= '0;
    end else begin
      if (valid_out && !stall) stat_issued <= stat_issued + CNT_W'(1);
      if (stall)               stat_stalls <= stat_stalls + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed bench for if_id_hazard_stage; counters built 4 bits wide to exercise wrap-around.
module tb_if_id_hazard_stage;

  localparam int          WIDTH = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] inst_in, pc_in, pc_plus4_in;
  logic             pc_mux_sel, ex_mem_read;
  logic [4:0]       ex_rd;
  logic [WIDTH-1:0] inst_out, pc_out, pc_plus4_out;
  logic             valid_out, stall, id_bubble;
  logic [CNT_W-1:0] stat_issued, stat_stalls;

  int compared;
  int mismatched;

  if_id_hazard_stage #(.WIDTH(WIDTH), .NOP(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .inst_in(inst_in), .pc_in(pc_in), .pc_plus4_in(pc_plus4_in),
    .pc_mux_sel(pc_mux_sel), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .inst_out(inst_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .valid_out(valid_out), .stall(stall), .id_bubble(id_bubble),
    .stat_issued(stat_issued), .stat_stalls(stat_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    inst_in     = inst;
    pc_in       = pc;
    pc_plus4_in = pc + 32'd4;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst_in = $urandom; pc_in = $urandom; pc_plus4_in = $urandom;
    pc_mux_sel = 1'($urandom); ex_mem_read = 1'($urandom); ex_rd = 5'($urandom);
    tick();
    tick();
    compared++; if (inst_out !== NOP) begin mismatched++; $display("FAIL reset_inst: got %h want %h", inst_out, NOP); end
    compared++; if (pc_out !== 32'd0) begin mismatched++; $display("FAIL reset_pc: got %h want 0", pc_out); end
    compared++; if (pc_plus4_out !== 32'd0) begin mismatched++; $display("FAIL reset_pc4: got %h want 0", pc_plus4_out); end
    compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", stall); end
    compared++; if (stat_issued !== 4'd0 || stat_stalls !== 4'd0) begin mismatched++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stat_issued, stat_stalls); end
    rst = 1'b1;
    pc_mux_sel = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    drive(32'h00500093, 32'h10);
    tick();
    compared++; if (inst_out !== 32'h00500093) begin mismatched++; $display("FAIL first_inst: got %h want 00500093", inst_out); end
    compared++; if (pc_out !== 32'h10 || pc_plus4_out !== 32'h14) begin mismatched++; $display("FAIL first_pc: got %h/%h want 10/14", pc_out, pc_plus4_out); end
    compared++; if (valid_out !== 1'b1) begin mismatched++; $display("FAIL first_valid: got %b want 1", valid_out); end
    compared++; if (stat_issued !== 4'd0) begin mismatched++; $display("FAIL first_issued: got %0d want 0", stat_issued); end
  endtask

  task automatic test_load_use();
    drive(32'h002081B3, 32'h14);           // add x3,x1,x2
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    drive(32'h00310233, 32'h18);           // add x4,x2,x3
    #1;
    compared++; if (stall !== 1'b1 || id_bubble !== 1'b1) begin mismatched++; $display("FAIL lu_stall: got %b/%b want 1/1", stall, id_bubble); end
    compared++; if (stat_issued !== 4'd1) begin mismatched++; $display("FAIL lu_issued_before: got %0d want 1", stat_issued); end
    tick();
    compared++; if (inst_out !== 32'h002081B3 || pc_out !== 32'h14) begin mismatched++; $display("FAIL lu_hold: got %h@%h want 002081b3@14", inst_out, pc_out); end
    compared++; if (stat_stalls !== 4'd1) begin mismatched++; $display("FAIL lu_stalls: got %0d want 1", stat_stalls); end
    compared++; if (stall !== 1'b0 || id_bubble !== 1'b0) begin mismatched++; $display("FAIL lu_hold_nostall: got %b/%b want 0/0", stall, id_bubble); end
    ex_mem_read = 1'b0;
    tick();
    compared++; if (inst_out !== 32'h00310233 || pc_out !== 32'h18 || valid_out !== 1'b1) begin mismatched++; $display("FAIL lu_release: got %h@%h v%b want 00310233@18 v1", inst_out, pc_out, valid_out); end
    compared++; if (stat_issued !== 4'd2 || stat_stalls !== 4'd1) begin mismatched++; $display("FAIL lu_counters: got %0d/%0d want 2/1", stat_issued, stat_stalls); end
  endtask

  task automatic test_no_false_hazard();
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL x0_no_stall: got %b want 0", stall); end
    ex_rd = 5'd3;
    #1;
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL rs2_stall: got %b want 1", stall); end
    ex_mem_read = 1'b0;
    drive(32'h000080B7, 32'h1C);           // lui x1,8 (rs1 field = 1)
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd1;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL lui_no_stall: got %b want 0", stall); end
    drive(32'h00208293, 32'h20);           // addi x5,x1,2 (rs2 field = 2)
    tick();
    ex_rd = 5'd2;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL addi_rs2_unused: got %b want 0", stall); end
    ex_rd = 5'd1;
    #1;
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL addi_rs1_stall: got %b want 1", stall); end
    ex_mem_read = 1'b0;
    compared++; if (stat_issued !== 4'd4) begin mismatched++; $display("FAIL nf_issued: got %0d want 4", stat_issued); end
  endtask

  task automatic test_flush();
    pc_mux_sel = 1'b1;
    drive(32'h00A00113, 32'h40);
    tick();
    compared++; if (inst_out !== NOP || valid_out !== 1'b0) begin mismatched++; $display("FAIL flush_nop: got %h v%b want 00000013 v0", inst_out, valid_out); end
    compared++; if (pc_out !== 32'h40 || pc_plus4_out !== 32'h44) begin mismatched++; $display("FAIL flush_pc: got %h/%h want 40/44", pc_out, pc_plus4_out); end
    compared++; if (stat_issued !== 4'd5) begin mismatched++; $display("FAIL flush_issued: got %0d want 5", stat_issued); end
    pc_mux_sel = 1'b0;
    drive(32'h002081B3, 32'h48);
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd1; pc_mux_sel = 1'b1;
    drive(32'h00A00113, 32'h50);
    #1;
    compared++; if (stall !== 1'b0 || id_bubble !== 1'b0) begin mismatched++; $display("FAIL flush_beats_stall: got %b/%b want 0/0", stall, id_bubble); end
    tick();
    compared++; if (inst_out !== NOP || valid_out !== 1'b0 || pc_out !== 32'h50) begin mismatched++; $display("FAIL flush_hazard_nop: got %h v%b @%h want 00000013 v0 @50", inst_out, valid_out, pc_out); end
    compared++; if (stat_issued !== 4'd6 || stat_stalls !== 4'd1) begin mismatched++; $display("FAIL flush_counters: got %0d/%0d want 6/1", stat_issued, stat_stalls); end
    pc_mux_sel = 1'b0; ex_mem_read = 1'b0;
  endtask

  task automatic test_async_reset_hold();
    drive(32'h002081B3, 32'h60);
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    #1;
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL ar_pre_stall: got %b want 1", stall); end
    #1 rst = 1'b0;
    #1;
    compared++; if (stall !== 1'b0 || id_bubble !== 1'b0) begin mismatched++; $display("FAIL ar_stall_drop: got %b/%b want 0/0", stall, id_bubble); end
    compared++; if (inst_out !== NOP || valid_out !== 1'b0 || pc_out !== 32'd0 || pc_plus4_out !== 32'd0) begin mismatched++; $display("FAIL ar_outputs: got %h v%b %h/%h want 00000013 v0 0/0", inst_out, valid_out, pc_out, pc_plus4_out); end
    compared++; if (stat_issued !== 4'd0 || stat_stalls !== 4'd0) begin mismatched++; $display("FAIL ar_counters: got %0d/%0d want 0/0", stat_issued, stat_stalls); end
    tick();
    ex_mem_read = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_counter_wrap();
    drive(32'h00500093, 32'h100);
    tick();
    for (int i = 0; i < 17; i++) begin
      drive(32'h00500093, 32'h104 + 32'(i) * 32'd4);
      tick();
      if (i == 15) begin
        compared++; if (stat_issued !== 4'd0) begin mismatched++; $display("FAIL wrap_16: got %0d want 0", stat_issued); end
      end
    end
    compared++; if (stat_issued !== 4'd1) begin mismatched++; $display("FAIL wrap_17: got %0d want 1", stat_issued); end
    compared++; if (stat_stalls !== 4'd0) begin mismatched++; $display("FAIL wrap_stalls: got %0d want 0", stat_stalls); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_async_reset_hold();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
